fifo_rd_drainer: RTL



---
 rtl/fifo_rd_drainer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_drainer.sv
`default_nettype none
// ============================================================================
// fifo_rd_drainer : async-FIFO read-side drainer with skid buffer and flush
// Rev 1.0
// ============================================================================
module fifo_rd_drainer #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int BUF_DEPTH = 2,
  parameter int UF_CNT_W  = 8
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                en,
  input  logic [ASIZE-1:0]    mrgn_cfg,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                ren,
  output logic                rptr_clr,
  input  logic [DSIZE-1:0]    rdata,
  output logic [ASIZE-1:0]    near_empty_mrgn,
  input  logic                empty,
  input  logic                near_empty,
  input  logic                under_flow,
  output logic                m_valid,
  output logic [DSIZE-1:0]    m_data,
  input  logic                m_ready,
  output logic                m_low,
  output logic                uf_err,
  output logic [UF_CNT_W-1:0] uf_cnt,
  output logic [15:0]         rd_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FL_WAIT   = 2'd1,
    FL_CLR    = 2'd2,
    FL_SETTLE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DSIZE-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0] occ;
  logic             inflight;
  logic             fl_hold;
  logic             pop;
  logic             in_run;
  logic             flush_go;

  assign in_run     = (state == RUN);
  assign flush_go   = in_run & flush_req;
  assign occ        = buf_cnt + CNT_W'(inflight);
  assign m_valid    = in_run & (buf_cnt != '0);
  assign m_data     = buf_mem[head];
  assign pop        = m_valid & m_ready;
  // m_ready feeds ren combinationally so a full buffer can refill while it drains
  assign ren        = ~rrst & in_run & en & ~flush_req & ~empty & ((occ < DEPTH_C) | pop);
  assign rptr_clr   = ~rrst & (state == FL_CLR);
  assign flush_done = ~rrst & (state == FL_SETTLE);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (flush_req) state_nxt = FL_WAIT;
      FL_WAIT:   if (!inflight && !fl_hold) state_nxt = FL_CLR;
      FL_CLR:    state_nxt = FL_SETTLE;
      FL_SETTLE: state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  // A read that landed alongside flush_req holds FL_WAIT one extra cycle so the
  // FIFO's own read-pointer advance settles before the pointer is cleared.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state   <= RUN;
      fl_hold <= 1'b0;
    end else begin
      state   <= state_nxt;
      fl_hold <= flush_go & inflight;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      head     <= '0;
      tail     <= '0;
      buf_cnt  <= '0;
      inflight <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      inflight <= ren;
      if (flush_go) begin
        head    <= '0;
        tail    <= '0;
        buf_cnt <= '0;
      end else if (in_run) begin
        if (inflight) begin
          buf_mem[tail] <= rdata;
          tail          <= tail + PTR_W'(1);
        end
        if (pop) head <= head + PTR_W'(1);
        buf_cnt <= buf_cnt + CNT_W'(inflight) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      near_empty_mrgn <= '0;
      m_low           <= 1'b0;
      uf_err          <= 1'b0;
      uf_cnt          <= '0;
      rd_cnt          <= '0;
    end else begin
      near_empty_mrgn <= mrgn_cfg;
      m_low           <= near_empty;
      if (under_flow) begin
        uf_err <= 1'b1;
        if (uf_cnt != {UF_CNT_W{1'b1}}) uf_cnt <= uf_cnt + UF_CNT_W'(1);
      end
      if (pop) rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
